// File: rtl/vend_pkg.sv
// Shared types for the vending change controller: FSM states, coin
// encodings and the 4-bit credit type.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } vend_state_e;

  typedef logic [3:0] credit_t;
  typedef logic [2:0] coin_t;

  localparam coin_t COIN_NONE = 3'd0;
  localparam coin_t COIN_1    = 3'd1;
  localparam coin_t COIN_2    = 3'd2;
  localparam coin_t COIN_5    = 3'd5;

  // Only 1, 2 and 5 are real coins; every other nonzero code is illegal.
  function automatic logic coin_legal(coin_t c);
    return (c == COIN_1) || (c == COIN_2) || (c == COIN_5);
  endfunction

endpackage

// File: rtl/vend_change_ctrl_if.sv
// Dispense/eject handshake bundle between the controller (master) and the
// motor/ejector mechanics (slave).
//
// Handshake: each channel transfers on a rising clk edge where valid and
// ready are both high. Once valid rises, the master holds valid and its
// payload (vend_id / chg_coin) unchanged until that transfer; ready may
// toggle freely and has no effect while valid is low.
import vend_pkg::*;

interface vend_change_ctrl_if;
  logic       vend_valid;
  logic [1:0] vend_id;
  logic       vend_ready;
  logic       chg_valid;
  coin_t      chg_coin;
  logic       chg_ready;

  modport master (
    output vend_valid, vend_id, chg_valid, chg_coin,
    input  vend_ready, chg_ready
  );

  modport slave (
    input  vend_valid, vend_id, chg_valid, chg_coin,
    output vend_ready, chg_ready
  );
endinterface

// File: rtl/vend_change_gen.sv
// Largest-coin selector: picks the biggest of 5/2/1 that still fits in the
// remaining credit, or no coin when the credit is zero.
import vend_pkg::*;

module vend_change_gen (
  input  credit_t balance,
  output coin_t   coin
);

  // Greedy pick of the next change coin
  always_comb begin
    coin = COIN_NONE;
    if (balance >= 4'd5) begin
      coin = COIN_5;
    end else if (balance >= 4'd2) begin
      coin = COIN_2;
    end else if (balance == 4'd1) begin
      coin = COIN_1;
    end
  end

endmodule

// File: rtl/vend_change_ctrl.sv
// Vending controller: accepts coins into a 4-bit credit, vends one of four
// products, then pays out any remainder coin by coin.
// Optional build macro VEND_TIMEOUT_EN adds an inactivity auto-refund in
// COLLECT after TIMEOUT_CYCLES quiet cycles.
import vend_pkg::*;

module vend_change_ctrl #(
  parameter int PRICE0         = 7,
  parameter int PRICE1         = 9,
  parameter int PRICE2         = 12,
  parameter int PRICE3         = 15,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  coin_t                     coin,
  input  logic                      sel_valid,
  input  logic [1:0]                sel_id,
  input  logic                      cancel,
  vend_change_ctrl_if.master        dsp,
  output credit_t                   balance,
  output logic                      coin_reject,
  output logic                      short_funds,
  output logic                      busy,
  output vend_state_e               state_dbg
);

  vend_state_e state;
  logic [1:0]  vend_id_q;
  credit_t     price_sel;
  coin_t       next_chg;
  logic [4:0]  coin_sum;
  logic        coin_present;
  logic        timeout_hit;

  assign coin_present = (coin != COIN_NONE);
  // One spare bit so an overfull deposit is detected instead of wrapping.
  assign coin_sum     = {1'b0, balance} + {2'b00, coin};

  // Price lookup for the product being selected this cycle
  always_comb begin
    price_sel = credit_t'(PRICE0);
    case (sel_id)
      2'd0: price_sel = credit_t'(PRICE0);
      2'd1: price_sel = credit_t'(PRICE1);
      2'd2: price_sel = credit_t'(PRICE2);
      2'd3: price_sel = credit_t'(PRICE3);
      default: price_sel = credit_t'(PRICE0);
    endcase
  end

  vend_change_gen u_change_gen (
    .balance (balance),
    .coin    (next_chg)
  );

`ifdef VEND_TIMEOUT_EN
  logic [31:0] idle_cnt;
  logic        activity;

  assign activity    = coin_present || sel_valid || cancel;
  assign timeout_hit = (state == ST_COLLECT) && !activity &&
                       (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

  // Count consecutive quiet cycles spent in COLLECT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if ((state != ST_COLLECT) || activity || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // Main FSM: credit bookkeeping, selection, vend and change payout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      balance     <= '0;
      vend_id_q   <= '0;
      coin_reject <= 1'b0;
      short_funds <= 1'b0;
    end else begin
      coin_reject <= 1'b0;
      short_funds <= 1'b0;
      case (state)
        ST_IDLE, ST_COLLECT: begin
          if ((state == ST_COLLECT) && cancel) begin
            // Refund everything; a coin offered alongside is handed back.
            state       <= ST_CHANGE;
            coin_reject <= coin_present;
          end else if ((state == ST_COLLECT) && sel_valid) begin
            if (balance >= price_sel) begin
              balance   <= balance - price_sel;
              vend_id_q <= sel_id;
              state     <= ST_VEND;
            end else begin
              short_funds <= 1'b1;
            end
            coin_reject <= coin_present;
          end else if (coin_present) begin
            if (coin_legal(coin) && !coin_sum[4]) begin
              balance <= coin_sum[3:0];
              state   <= ST_COLLECT;
            end else begin
              coin_reject <= 1'b1;
            end
          end else if (timeout_hit) begin
            state <= ST_CHANGE;
          end
        end
        ST_VEND: begin
          coin_reject <= coin_present;
          if (dsp.vend_ready) begin
            state <= (balance != '0) ? ST_CHANGE : ST_IDLE;
          end
        end
        ST_CHANGE: begin
          coin_reject <= coin_present;
          if (balance == '0) begin
            state <= ST_IDLE;
          end else if (dsp.chg_ready) begin
            balance <= balance - {1'b0, next_chg};
            if (balance == {1'b0, next_chg}) begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs decode straight from registered state and credit,
  // so they drop to zero the moment reset is asserted.
  assign dsp.vend_valid = (state == ST_VEND);
  assign dsp.vend_id    = (state == ST_VEND) ? vend_id_q : 2'd0;
  assign dsp.chg_valid  = (state == ST_CHANGE) && (balance != '0);
  assign dsp.chg_coin   = dsp.chg_valid ? next_chg : COIN_NONE;
  assign busy           = (state == ST_VEND) || (state == ST_CHANGE);
  assign state_dbg      = state;

endmodule

// File: tb/tb_vend_change_ctrl.sv
// Bench for vend_change_ctrl: directed scenarios followed by random traffic,
// all checked every cycle against a behavioural model of the machine.
import vend_pkg::*;

module tb_vend_change_ctrl;

  localparam int TO = 10;
  localparam int M_IDLE = 0, M_COLLECT = 1, M_VEND = 2, M_CHANGE = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  coin_t       coin = '0;
  logic        sel_valid = 1'b0;
  logic [1:0]  sel_id = '0;
  logic        cancel = 1'b0;
  credit_t     balance;
  logic        coin_reject, short_funds, busy;
  vend_state_e state_dbg;

  vend_change_ctrl_if dsp_if ();

  vend_change_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .coin        (coin),
    .sel_valid   (sel_valid),
    .sel_id      (sel_id),
    .cancel      (cancel),
    .dsp         (dsp_if.master),
    .balance     (balance),
    .coin_reject (coin_reject),
    .short_funds (short_funds),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // ---------------- reference model ----------------
  int price[4] = '{7, 9, 12, 15};
  int m_st, m_bal, m_vid, m_rej, m_sf, m_idle;
  logic [2:0] exp_q[$];   // change coins still owed, in payout order
  int checks = 0;
  int passes = 0;

  task automatic model_reset();
    m_st = M_IDLE; m_bal = 0; m_vid = 0; m_rej = 0; m_sf = 0; m_idle = 0;
    exp_q.delete();
  endtask

  // Refund = greedy split of the whole credit into 5s, 2s and 1s.
  task automatic start_refund();
    int r;
    r = m_bal;
    m_st = M_CHANGE;
    while (r > 0) begin
      if (r >= 5) begin exp_q.push_back(3'd5); r -= 5; end
      else if (r >= 2) begin exp_q.push_back(3'd2); r -= 2; end
      else begin exp_q.push_back(3'd1); r -= 1; end
    end
  endtask

  task automatic model_edge();
    int st, c;
    bit used;
    st = m_st; c = int'(coin); used = 0;
    m_rej = 0; m_sf = 0;
    if (st == M_IDLE || st == M_COLLECT) begin
      if (st == M_COLLECT && cancel) begin
        used = 1; start_refund();
      end else if (st == M_COLLECT && sel_valid) begin
        used = 1;
        if (m_bal >= price[sel_id]) begin
          m_bal -= price[sel_id]; m_vid = int'(sel_id); m_st = M_VEND;
        end else m_sf = 1;
      end
      if (c != 0) begin
        if (!used && (c == 1 || c == 2 || c == 5) && (m_bal + c <= 15)) begin
          m_bal += c; m_st = M_COLLECT;
        end else m_rej = 1;
      end
    end else if (st == M_VEND) begin
      if (c != 0) m_rej = 1;
      if (dsp_if.vend_ready) begin
        if (m_bal > 0) start_refund(); else m_st = M_IDLE;
      end
    end else begin
      if (c != 0) m_rej = 1;
      if (dsp_if.chg_ready && exp_q.size() > 0) begin
        m_bal -= int'(exp_q.pop_front());
        if (m_bal == 0) m_st = M_IDLE;
      end
    end
`ifdef VEND_TIMEOUT_EN
    if (st == M_COLLECT) begin
      if (c != 0 || sel_valid || cancel) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == TO) begin m_idle = 0; start_refund(); end
      end
    end else m_idle = 0;
`endif
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_outputs();
    int exp_coin;
    exp_coin = (m_st == M_CHANGE && exp_q.size() > 0) ? int'(exp_q[0]) : 0;
    check("balance",     32'(balance),            32'(m_bal));
    check("vend_valid",  32'(dsp_if.vend_valid),  32'(m_st == M_VEND));
    check("vend_id",     32'(dsp_if.vend_id),     32'((m_st == M_VEND) ? m_vid : 0));
    check("chg_valid",   32'(dsp_if.chg_valid),   32'(m_st == M_CHANGE));
    check("chg_coin",    32'(dsp_if.chg_coin),    32'(exp_coin));
    check("coin_reject", 32'(coin_reject),        32'(m_rej));
    check("short_funds", 32'(short_funds),        32'(m_sf));
    check("busy",        32'(busy),               32'(m_st == M_VEND || m_st == M_CHANGE));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic put_coin(input int c);
    coin = coin_t'(c); tick(); coin = '0;
  endtask

  task automatic select(input int id);
    sel_valid = 1'b1; sel_id = 2'(id); tick(); sel_valid = 1'b0;
  endtask

  task automatic drain();
    dsp_if.vend_ready = 1'b1; dsp_if.chg_ready = 1'b1;
    for (int i = 0; i < 40 && m_st != M_IDLE; i++) tick();
    check("drain_idle", 32'(state_dbg), 32'(ST_IDLE));
    dsp_if.vend_ready = 1'b0; dsp_if.chg_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_balance",    32'(balance), 32'd0);
    check("rst_state",      32'(state_dbg), 32'(ST_IDLE));
    check("rst_vend_valid", 32'(dsp_if.vend_valid), 32'd0);
    check("rst_chg_valid",  32'(dsp_if.chg_valid), 32'd0);
    check("rst_chg_coin",   32'(dsp_if.chg_coin), 32'd0);
    check("rst_busy",       32'(busy), 32'd0);
    check("rst_pulses",     32'({coin_reject, short_funds}), 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int r;
    dsp_if.vend_ready = 1'b0;
    dsp_if.chg_ready  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Exact payment for product 0: vend, no change
    put_coin(5); put_coin(2); select(0);
    check("exact_vend_id", 32'(dsp_if.vend_id), 32'd0);
    dsp_if.vend_ready = 1'b1; tick(); dsp_if.vend_ready = 1'b0;
    check("exact_idle", 32'(state_dbg), 32'(ST_IDLE));
    check("exact_no_chg", 32'(dsp_if.chg_valid), 32'd0);

    // 12 in, product 1 at 9: change 2 then 1
    put_coin(5); put_coin(5); put_coin(2); select(1);
    dsp_if.vend_ready = 1'b1; tick(); dsp_if.vend_ready = 1'b0;
    check("chg_first", 32'(dsp_if.chg_coin), 32'd2);
    dsp_if.chg_ready = 1'b1; tick();
    check("chg_second", 32'(dsp_if.chg_coin), 32'd1);
    drain();

    // Overfill at 14 is rejected, topping up to 15 is accepted
    put_coin(5); put_coin(5); put_coin(2); put_coin(2);
    put_coin(2);
    check("overfill_reject", 32'(coin_reject), 32'd1);
    put_coin(1);
    check("fill_15", 32'(balance), 32'd15);
    put_coin(7);
    check("illegal_reject", 32'(coin_reject), 32'd1);
    cancel = 1'b1; tick(); cancel = 1'b0;
    drain();

    // Cancel beats select at 8; payout held while chg_ready is low
    put_coin(5); put_coin(2); put_coin(1);
    cancel = 1'b1; sel_valid = 1'b1; sel_id = 2'd0; tick();
    cancel = 1'b0; sel_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("chg_hold", 32'(dsp_if.chg_coin), 32'd5);
    end
    drain();

    // Short funds at 6 for product 0
    put_coin(5); put_coin(1); select(0);
    check("short_pulse", 32'(short_funds), 32'd1);
    tick();
    check("short_clear", 32'(short_funds), 32'd0);
    check("short_collect", 32'(state_dbg), 32'(ST_COLLECT));
    cancel = 1'b1; tick(); cancel = 1'b0;
    drain();

    // Reset in the middle of a payout
    put_coin(5); put_coin(5);
    cancel = 1'b1; tick(); cancel = 1'b0;
    tick();
    check("pre_rst_chg", 32'(dsp_if.chg_valid), 32'd1);
    #2;
    do_reset();

`ifdef VEND_TIMEOUT_EN
    // Quiet COLLECT auto-refunds after TO cycles
    put_coin(5);
    for (int i = 0; i < TO - 1; i++) tick();
    check("to_not_yet", 32'(state_dbg), 32'(ST_COLLECT));
    tick();
    check("to_fired", 32'(state_dbg), 32'(ST_CHANGE));
    drain();
`endif

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5) coin = 3'd0;
      else if (r == 5) coin = 3'd1;
      else if (r == 6) coin = 3'd2;
      else if (r == 7) coin = 3'd5;
      else coin = coin_t'($urandom_range(3, 7));
      sel_valid = ($urandom_range(0, 5) == 0);
      sel_id    = 2'($urandom_range(0, 3));
      cancel    = ($urandom_range(0, 11) == 0);
      dsp_if.vend_ready = ($urandom_range(0, 2) != 0);
      dsp_if.chg_ready  = ($urandom_range(0, 2) != 0);
      tick();
    end
    coin = '0; sel_valid = 1'b0; cancel = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vend_change_ctrl.md
VEND_CHANGE_CTRL -- requirements
Module: vend_change_ctrl

Interface
REQ-001 Parameter PRICE0, default 7, price of product 0 in coin units (1..15).
REQ-002 Parameter PRICE1, default 9, price of product 1.
REQ-003 Parameter PRICE2, default 12, price of product 2.
REQ-004 Parameter PRICE3, default 15, price of product 3.
REQ-005 Parameter TIMEOUT_CYCLES, default 1000, inactivity limit in COLLECT (used only with VEND_TIMEOUT_EN).
REQ-006 Port clk  input  1  single clock; all logic on rising edge.
REQ-007 Port reset  input  1  asynchronous, active-high reset.
REQ-008 Port coin  input  3  coin value each cycle; 1, 2 or 5 valid, 0 = none, others illegal.
REQ-009 Port sel_valid  input  1  product selection strobe.
REQ-010 Port sel_id  input  2  selected product index.
REQ-011 Port cancel  input  1  refund request.
REQ-012 Port vend_valid  output  1  dispense-motor request, held until accepted.
REQ-013 Port vend_id  output  2  product being dispensed.
REQ-014 Port vend_ready  input  1  motor accepts request when high with vend_valid.
REQ-015 Port chg_valid  output  1  change-coin eject request.
REQ-016 Port chg_coin  output  3  coin value to eject (5, 2 or 1).
REQ-017 Port chg_ready  input  1  ejector accepts coin when high with chg_valid.
REQ-018 Port balance  output  4  current credit.
REQ-019 Port coin_reject  output  1  one-cycle pulse: offered coin returned, not credited.
REQ-020 Port short_funds  output  1  one-cycle pulse: selection refused, credit below price.
REQ-021 Port busy  output  1  high in VEND and CHANGE.

Function
REQ-022 States: IDLE, COLLECT, VEND, CHANGE; transitions on rising clk only.
REQ-023 IDLE/COLLECT, legal coin, balance+coin <= 15: credit added on that edge, state -> COLLECT.
REQ-024 Legal coin with balance+coin > 15, illegal coin value, or any nonzero coin in VEND/CHANGE: no credit, coin_reject high the next cycle.
REQ-025 COLLECT priority per cycle: cancel > sel_valid > coin; lower-priority coin that cycle is rejected per REQ-024.
REQ-026 COLLECT, cancel: state -> CHANGE, full balance refunded.
REQ-027 COLLECT, sel_valid, balance >= PRICE[sel_id]: vend_id latched, balance -= price, state -> VEND.
REQ-028 COLLECT, sel_valid, balance < price: state unchanged, short_funds high next cycle.
REQ-029 sel_valid or cancel in IDLE: ignored.
REQ-030 VEND: vend_valid high, vend_id stable until vend_ready sampled high; then -> CHANGE if balance > 0, else IDLE.
REQ-031 CHANGE: chg_coin = largest of 5/2/1 not exceeding balance; on chg_valid&&chg_ready balance -= chg_coin; balance 0 -> IDLE.
REQ-032 chg_coin stable while chg_valid high and chg_ready low; cancel ignored in VEND/CHANGE.
REQ-033 Arithmetic 4-bit unsigned; balance never wraps or goes negative.

Reset
REQ-034 Reset asserted at any time: state IDLE, balance 0, all outputs 0 immediately; credit in flight is lost.

Configuration
REQ-035 VEND_TIMEOUT_EN defined: counter clears on any COLLECT activity; after TIMEOUT_CYCLES idle cycles in COLLECT, state -> CHANGE (auto-refund).
REQ-036 VEND_TIMEOUT_EN undefined: no counter; COLLECT held indefinitely.

Structure
REQ-037 Package vend_pkg: state enum, coin constants (COIN_1/2/5), 4-bit credit type.
REQ-038 Sub-module vend_change_gen: combinational largest-coin selector for REQ-031.

Verification
REQ-039 Coins 5,2, select product 0 -> vend_valid, vend_id 0; after vend_ready balance 0, IDLE, no chg_valid.
REQ-040 Coins 5,5,2 (12), select product 1 (9) -> vend; then chg_valid with chg_coin 2, then 1; balance 0, IDLE.
REQ-041 Balance 14, coin 2 -> coin_reject, balance 14; coin 1 -> balance 15.
REQ-042 Balance 8, cancel with simultaneous sel_valid -> refund 5 then 2 then 1, no vend_valid; chg_ready low 3 cycles -> chg_coin held.
REQ-043 Balance 6, select product 0 -> short_funds one cycle, COLLECT, balance 6.
REQ-044 Reset mid-CHANGE with chg_valid high -> all outputs 0, balance 0, IDLE; with VEND_TIMEOUT_EN, TIMEOUT_CYCLES=10, coin 5 then idle -> refund after 10 cycles.
